// File: rtl/lcd_bus_pkg.sv
// -----------------------------------------------------------------------------
// lcd_bus_pkg
// Shared definitions for the 16-bit 8080-style TFT bus engines.
//   - lcd_state_t : read-engine FSM state encoding
//   - *_DEF       : default phase timings for the 80 MHz system clock
//   - READ_ID / RAMRD : common controller command words
//   - lcd_ctrl_t / ctrl_for() : pin-control levels decoded from an FSM state
// No ports (package).
// -----------------------------------------------------------------------------
package lcd_bus_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        REQ         = 4'd1,
        CMD_LO      = 4'd2,
        CMD_HI      = 4'd3,
        TURN        = 4'd4,
        RD_LO       = 4'd5,
        RD_HI       = 4'd6,
        FIN         = 4'd7,
        WAIT_EN_LOW = 4'd8
    } lcd_state_t;

    // Phase timings in clk_80MHz cycles (12.5 ns each).
    localparam int T_WRL_DEF       = 3;
    localparam int T_WRH_DEF       = 3;
    localparam int T_TURN_DEF      = 2;
    localparam int T_RDL_DEF       = 8;
    localparam int T_RDH_DEF       = 8;
    localparam int DUMMY_READS_DEF = 1;

    // Width of the phase down-counter; phases up to 256 cycles.
    localparam int PHASE_W = 8;

    localparam logic [15:0] READ_ID = 16'h00D3;
    localparam logic [15:0] RAMRD   = 16'h002E;

    // Pin-control levels; cs/wr/rd active-low, rs = 0 selects command.
    typedef struct packed {
        logic cs;
        logic rs;
        logic wr;
        logic rd;
        logic oe;
        logic req;
        logic done;
    } lcd_ctrl_t;

    localparam lcd_ctrl_t CTRL_IDLE = '{cs: 1'b1, rs: 1'b1, wr: 1'b1, rd: 1'b1,
                                        oe: 1'b0, req: 1'b0, done: 1'b0};

    // Control levels that hold for the whole time the FSM sits in state s.
    function automatic lcd_ctrl_t ctrl_for(input lcd_state_t s);
        lcd_ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            REQ: begin
                c.req = 1'b1;
            end
            CMD_LO: begin
                c.req = 1'b1; c.cs = 1'b0; c.rs = 1'b0; c.oe = 1'b1; c.wr = 1'b0;
            end
            CMD_HI: begin
                c.req = 1'b1; c.cs = 1'b0; c.rs = 1'b0; c.oe = 1'b1;
            end
            // oe drops on the same edge RS rises, so RS never sees a driven bus.
            TURN: begin
                c.req = 1'b1; c.cs = 1'b0;
            end
            RD_LO: begin
                c.req = 1'b1; c.cs = 1'b0; c.rd = 1'b0;
            end
            RD_HI: begin
                c.req = 1'b1; c.cs = 1'b0;
            end
            FIN: begin
                c.done = 1'b1;
            end
            default: begin
                c = CTRL_IDLE;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// -----------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter used to time each bus phase. Loaded with
// (phase length - 1) on the edge that enters a phase; zero is high during the
// last cycle of the phase.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   load     in   load load_val this cycle
//   load_val in   W  value to load
//   zero     out  counter is zero
// -----------------------------------------------------------------------------
module lcd_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// -----------------------------------------------------------------------------
// lcd_bus_reader
// Read-side engine for the 16-bit 8080-style TFT bus (clk_80MHz domain).
// Acquires the shared pins, writes one command word, turns the bus around,
// then issues DUMMY_READS + rd_count LCD_RD strobes, returning every
// non-dummy word with a one-cycle dout_valid strobe.
//
// Build option: LCD_RD_INREG_EN
//   defined   - LCD_DATA_i goes through an input register; words are captured
//               at the end of the first RD_HI cycle, so dout/dout_valid come
//               one cycle later. Requires T_RDH >= 2.
//   undefined - LCD_DATA_i captured directly on the edge that ends RD_LO.
//
// Request handshake (en/done): the requester raises en and holds it until it
// sees the one-cycle done pulse. cmd and rd_count are sampled on the accepting
// edge (IDLE with en=1). After done the engine waits for en=0 before it can
// accept again, so an en left high after done never starts a second transfer;
// en dropping mid-transfer is ignored.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   en, cmd, rd_count request, command word, number of words to return
//   done              one-cycle completion pulse
//   dout, dout_valid  last captured word; one-cycle strobe per word
//   bus_req, bus_gnt  shared-pin arbitration (gnt sampled only in REQ)
//   LCD_CS/RS/WR/RD   bus controls (active-low except RS, 0 = command)
//   LCD_DATA_o/_oe/_i data out, tristate enable (1 = drive), data in
//   dbg_state         current FSM state (lcd_state_t encoding)
// -----------------------------------------------------------------------------
module lcd_bus_reader
    import lcd_bus_pkg::*;
#(
    parameter int T_WRL       = T_WRL_DEF,
    parameter int T_WRH       = T_WRH_DEF,
    parameter int T_TURN      = T_TURN_DEF,
    parameter int T_RDL       = T_RDL_DEF,
    parameter int T_RDH       = T_RDH_DEF,
    parameter int DUMMY_READS = DUMMY_READS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] cmd,
    input  logic [7:0]  rd_count,
    output logic        done,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        LCD_CS,
    output logic        LCD_RS,
    output logic        LCD_WR,
    output logic        LCD_RD,
    output logic [15:0] LCD_DATA_o,
    output logic        LCD_DATA_oe,
    input  logic [15:0] LCD_DATA_i,
    output logic [3:0]  dbg_state
);

    lcd_state_t         state, state_d;
    lcd_ctrl_t          ctrl;
    logic [15:0]        cmd_q;
    logic [8:0]         total_q;   // DUMMY_READS + rd_count, 9 bits so 3 + 255 does not wrap
    logic [8:0]         idx;       // strobes completed so far
    logic               ph_zero;
    logic               ph_load;
    logic [PHASE_W-1:0] ph_len;
    logic               rd_end;    // edge that ends an RD_LO phase
    logic               keep;      // current strobe is past the dummy reads
    logic               cap_en;
    logic [15:0]        cap_data;

    assign dbg_state = state;
    assign rd_end    = (state == RD_LO) && ph_zero;
    assign keep      = (idx >= 9'(DUMMY_READS));

    // ---------------- next-state ----------------
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:        if (en)      state_d = REQ;
            REQ:         if (bus_gnt) state_d = CMD_LO;
            CMD_LO:      if (ph_zero) state_d = CMD_HI;
            CMD_HI:      if (ph_zero) state_d = TURN;
            TURN:        if (ph_zero) state_d = (total_q == '0) ? FIN : RD_LO;
            RD_LO:       if (ph_zero) state_d = RD_HI;
            // idx was already advanced at the end of RD_LO.
            RD_HI:       if (ph_zero) state_d = (idx < total_q) ? RD_LO : FIN;
            FIN:                      state_d = WAIT_EN_LOW;
            WAIT_EN_LOW: if (!en)     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Phase length loaded on every state entry.
    always_comb begin
        ph_load = (state_d != state);
        ph_len  = '0;
        case (state_d)
            CMD_LO:  ph_len = PHASE_W'(T_WRL - 1);
            CMD_HI:  ph_len = PHASE_W'(T_WRH - 1);
            TURN:    ph_len = PHASE_W'(T_TURN - 1);
            RD_LO:   ph_len = PHASE_W'(T_RDL - 1);
            RD_HI:   ph_len = PHASE_W'(T_RDH - 1);
            default: ph_len = '0;
        endcase
    end

    lcd_phase_timer #(
        .W (PHASE_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_len),
        .zero     (ph_zero)
    );

    // ---------------- state and registered pins ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ctrl       <= CTRL_IDLE;
            LCD_DATA_o <= '0;
        end else begin
            state      <= state_d;
            ctrl       <= ctrl_for(state_d);
            LCD_DATA_o <= (state_d == CMD_LO || state_d == CMD_HI) ? cmd_q : '0;
        end
    end

    assign LCD_CS      = ctrl.cs;
    assign LCD_RS      = ctrl.rs;
    assign LCD_WR      = ctrl.wr;
    assign LCD_RD      = ctrl.rd;
    assign LCD_DATA_oe = ctrl.oe;
    assign bus_req     = ctrl.req;
    assign done        = ctrl.done;

    // ---------------- request latch and strobe counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q   <= '0;
            total_q <= '0;
            idx     <= '0;
        end else begin
            if (state == IDLE && en) begin
                cmd_q   <= cmd;
                total_q <= 9'(DUMMY_READS) + {1'b0, rd_count};
                idx     <= '0;
            end
            if (rd_end) begin
                idx <= idx + 9'd1;
            end
        end
    end

    // ---------------- capture path ----------------
`ifdef LCD_RD_INREG_EN
    logic [15:0] din_q;
    logic        cap_pend;

    // din_q holds the pins as seen on the RD_LO-ending edge; it is committed
    // to dout one cycle later, inside the first RD_HI cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q    <= '0;
            cap_pend <= 1'b0;
        end else begin
            din_q    <= LCD_DATA_i;
            cap_pend <= rd_end && keep;
        end
    end

    assign cap_en   = cap_pend;
    assign cap_data = din_q;
`else
    assign cap_en   = rd_end && keep;
    assign cap_data = LCD_DATA_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= cap_en;
            if (cap_en) begin
                dout <= cap_data;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
`timescale 1ns/1ps
module tb_lcd_bus_reader;
    import lcd_bus_pkg::*;

`ifdef LCD_RD_INREG_EN
    localparam int VLAT = 1;
`else
    localparam int VLAT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #6 clk = ~clk;

    // ---------------- DUT A: default parameters ----------------
    logic        en, bus_gnt, done, dout_valid, bus_req;
    logic [15:0] cmd, dout, LCD_DATA_o, lcd_din;
    logic [7:0]  rd_count;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_oe;
    logic [3:0]  dbg_state;

    lcd_bus_reader u_dut (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .rd_count(rd_count),
        .done(done), .dout(dout), .dout_valid(dout_valid),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
        .LCD_DATA_o(LCD_DATA_o), .LCD_DATA_oe(LCD_DATA_oe), .LCD_DATA_i(lcd_din),
        .dbg_state(dbg_state)
    );

    // ---------------- DUT B: no dummy reads ----------------
    logic        en_b, gnt_b, done_b, dout_valid_b, bus_req_b;
    logic [15:0] cmd_b, dout_b, data_o_b, din_b;
    logic [7:0]  rdc_b;
    logic        cs_b, rs_b, wr_b, rd_b, oe_b;
    logic [3:0]  dbg_b;

    lcd_bus_reader #(.DUMMY_READS(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .cmd(cmd_b), .rd_count(rdc_b),
        .done(done_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .bus_req(bus_req_b), .bus_gnt(gnt_b),
        .LCD_CS(cs_b), .LCD_RS(rs_b), .LCD_WR(wr_b), .LCD_RD(rd_b),
        .LCD_DATA_o(data_o_b), .LCD_DATA_oe(oe_b), .LCD_DATA_i(din_b),
        .dbg_state(dbg_b)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [15:0] rd_tbl[4];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // monitor results, DUT A
    int a_wr_falls, a_wr_fall_cyc, a_wr_width, a_rd_falls, a_rd_first_cyc;
    int a_rd_rise_cyc, a_rd_lo_bad, a_rd_hi_bad, a_valids, a_done_cnt;
    int a_cs_bad, a_rs_oe_bad;
    logic [15:0] a_wr_data;
    logic a_wr_rs, a_wr_oe;
    // monitor results, DUT B
    int b_wr_fall_cyc = 0, b_rd_falls = 0, b_rs_rise_cyc = 0, b_oe_fall_cyc = 0;
    int b_rs_oe_bad = 0, b_valids = 0, b_done_cyc = 0;

    // Panel model: the word presented while RD is low depends on strobe number.
    always_comb begin
        lcd_din = 16'hDEAD;
        if (a_rd_falls >= 1 && a_rd_falls <= 4) lcd_din = rd_tbl[a_rd_falls-1];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        a_wr_falls = 0; a_wr_fall_cyc = 0; a_wr_width = 0; a_rd_falls = 0;
        a_rd_first_cyc = 0; a_rd_lo_bad = 0; a_rd_hi_bad = 0; a_valids = 0;
        a_done_cnt = 0; a_cs_bad = 0; a_rs_oe_bad = 0;
        exp_q.delete();
    endtask

    // Samples both DUTs on every falling clock edge.
    task automatic mon_loop();
        logic pwr, prd, pcs, pwr_b, prd_b, prs_b, poe_b;
        int wr_run, rd_run;
        logic [15:0] e;
        pwr = 1; prd = 1; pcs = 1; pwr_b = 1; prd_b = 1; prs_b = 1; poe_b = 0;
        wr_run = 0; rd_run = 0;
        forever begin
            @(negedge clk);
            cyc++;
            // WR pulses
            if (!LCD_WR) begin
                if (pwr) begin
                    a_wr_falls++; a_wr_fall_cyc = cyc;
                    a_wr_rs = LCD_RS; a_wr_data = LCD_DATA_o; a_wr_oe = LCD_DATA_oe;
                    wr_run = 0;
                end
                wr_run++;
            end else if (!pwr) begin
                a_wr_width = wr_run;
            end
            // RD pulses
            if (!LCD_RD) begin
                if (prd) begin
                    a_rd_falls++;
                    if (a_rd_falls == 1) a_rd_first_cyc = cyc;
                    else if (cyc - a_rd_rise_cyc != T_RDH_DEF) a_rd_hi_bad++;
                    rd_run = 0;
                end
                rd_run++;
            end else if (!prd) begin
                if (rd_run != T_RDL_DEF) a_rd_lo_bad++;
                a_rd_rise_cyc = cyc;
            end
            // returned words
            if (dout_valid) begin
                a_valids++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("dout", 32'(dout), 32'(e));
                    check_eq("valid_latency", 32'(cyc - a_rd_rise_cyc), 32'(VLAT));
                end
            end
            if (done) a_done_cnt++;
            if (!pcs && LCD_CS && !done && !rst) a_cs_bad++;
            if (!LCD_CS && LCD_RS && LCD_DATA_oe) a_rs_oe_bad++;
            pwr = LCD_WR; prd = LCD_RD; pcs = LCD_CS;
            // DUT B
            if (!wr_b && pwr_b) b_wr_fall_cyc = cyc;
            if (!rd_b && prd_b) b_rd_falls++;
            if (rs_b && !prs_b) b_rs_rise_cyc = cyc;
            if (!oe_b && poe_b) b_oe_fall_cyc = cyc;
            if (!cs_b && rs_b && oe_b) b_rs_oe_bad++;
            if (dout_valid_b) b_valids++;
            if (done_b) b_done_cyc = cyc;
            pwr_b = wr_b; prd_b = rd_b; prs_b = rs_b; poe_b = oe_b;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_req(input logic [15:0] c, input logic [7:0] n);
        @(posedge clk); #1;
        cmd = c; rd_count = n; en = 1'b1;
    endtask

    task automatic wait_done(input string tag, input bit drop_en);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
        if (drop_en) begin
            @(posedge clk); #1 en = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int g_base;
        rst = 1'b1; en = 1'b0; cmd = '0; rd_count = '0; bus_gnt = 1'b0;
        en_b = 1'b0; cmd_b = '0; rdc_b = '0; gnt_b = 1'b1; din_b = 16'h1234;
        rd_tbl[0] = 16'h0000; rd_tbl[1] = 16'h0000; rd_tbl[2] = 16'h9488; rd_tbl[3] = 16'h0044;
        clear_mon();
        fork
            mon_loop();
        join_none

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pins", 32'({LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_oe}), 32'b11110);
        check_eq("rst_req_done_valid", 32'({bus_req, done, dout_valid}), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_data_o", 32'(LCD_DATA_o), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1 rst = 1'b0;

        // ID read: grant tied high, 1 dummy + 3 words
        clear_mon();
        bus_gnt = 1'b1;
        exp_q.push_back(16'h0000); exp_q.push_back(16'h9488); exp_q.push_back(16'h0044);
        start_req(READ_ID, 8'd3);
        wait_done("id", 1);
        check_eq("id_wr_pulses", 32'(a_wr_falls), 32'd1);
        check_eq("id_wr_width", 32'(a_wr_width), 32'd3);
        check_eq("id_wr_rs", 32'(a_wr_rs), 32'd0);
        check_eq("id_wr_oe", 32'(a_wr_oe), 32'd1);
        check_eq("id_wr_data", 32'(a_wr_data), 32'h00D3);
        check_eq("id_rd_pulses", 32'(a_rd_falls), 32'd4);
        check_eq("id_rd_low_width_errs", 32'(a_rd_lo_bad), 32'd0);
        check_eq("id_rd_high_width_errs", 32'(a_rd_hi_bad), 32'd0);
        check_eq("id_first_rd_delay", 32'(a_rd_first_cyc - a_wr_fall_cyc), 32'd8);
        check_eq("id_valids", 32'(a_valids), 32'd3);
        check_eq("id_done_pulses", 32'(a_done_cnt), 32'd1);
        check_eq("id_cs_glitches", 32'(a_cs_bad), 32'd0);
        check_eq("id_rs_while_driving", 32'(a_rs_oe_bad), 32'd0);
        check_eq("id_exp_left", 32'(exp_q.size()), 32'd0);
        check_eq("id_dout_hold", 32'(dout), 32'h0044);

        // Grant delayed 20 cycles
        clear_mon();
        bus_gnt = 1'b0;
        rd_tbl[0] = 16'hAAAA; rd_tbl[1] = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        start_req(RAMRD, 8'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("gnt_wait_req", 32'(bus_req), 32'd1);
        check_eq("gnt_wait_pins", 32'({LCD_CS, LCD_WR, LCD_RD, LCD_DATA_oe}), 32'b1110);
        check_eq("gnt_wait_wr_falls", 32'(a_wr_falls), 32'd0);
        @(posedge clk); #1 bus_gnt = 1'b1;
        g_base = cyc;
        wait_done("gnt", 1);
        check_eq("gnt_wr_fall_cycle", 32'(a_wr_fall_cyc - g_base), 32'd2);
        check_eq("gnt_wr_data", 32'(a_wr_data), 32'(RAMRD));
        check_eq("gnt_first_rd_delay", 32'(a_rd_first_cyc - a_wr_fall_cyc), 32'd8);
        check_eq("gnt_valids", 32'(a_valids), 32'd1);

        // Command-only on the zero-dummy instance
        @(posedge clk); #1 cmd_b = 16'h0029; rdc_b = 8'd0; en_b = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmdonly_done_seen", 32'(done_b), 32'd1);
        @(posedge clk); #1 en_b = 1'b0;
        repeat (2) @(posedge clk);
        check_eq("cmdonly_done_delay", 32'(b_done_cyc - b_wr_fall_cyc), 32'd8);
        check_eq("cmdonly_rs_rise_delay", 32'(b_rs_rise_cyc - b_wr_fall_cyc), 32'd6);
        check_eq("cmdonly_oe_first", 32'(b_oe_fall_cyc <= b_rs_rise_cyc && b_oe_fall_cyc > 0), 32'd1);
        check_eq("cmdonly_rs_while_driving", 32'(b_rs_oe_bad), 32'd0);
        check_eq("cmdonly_rd_strobes", 32'(b_rd_falls), 32'd0);
        check_eq("cmdonly_valids", 32'(b_valids), 32'd0);

        // Handshake: en held after done, then a 1-cycle low restarts
        clear_mon();
        start_req(READ_ID, 8'd0);
        wait_done("hs1", 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("hs_no_restart_req", 32'(bus_req), 32'd0);
        check_eq("hs_wait_state", 32'(dbg_state), 32'(WAIT_EN_LOW));
        check_eq("hs_wr_falls_1", 32'(a_wr_falls), 32'd1);
        check_eq("hs_dout_hold", 32'(dout), 32'h5A5A);
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("hs_restart_req", 32'(bus_req), 32'd1);
        wait_done("hs2", 1);
        check_eq("hs_wr_falls_2", 32'(a_wr_falls), 32'd2);
        check_eq("hs_done_pulses", 32'(a_done_cnt), 32'd2);
        check_eq("hs_valids", 32'(a_valids), 32'd0);

        // Async reset in the second RD_LO
        clear_mon();
        start_req(READ_ID, 8'd3);
        n = 0;
        while (a_rd_falls < 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check_eq("arst_reached_rd2", 32'(a_rd_falls >= 2), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1; en = 1'b0;
        #1;
        check_eq("arst_pins", 32'({LCD_RD, LCD_CS, LCD_WR, LCD_DATA_oe, bus_req}), 32'b11100);
        check_eq("arst_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        check_eq("arst_valids", 32'(a_valids), 32'd0);
        check_eq("arst_done", 32'(a_done_cnt), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
